// File: rtl/am_prototype_trainer_pkg.sv
// am_prototype_trainer_pkg
//   Shared definitions for the prototype trainer: default dimensions, the
//   trainer FSM state encoding and the ceilLog2 width helper.
//   No ports.
//   Optional build macro used by the trainer: TRAIN_TIEBREAK_EN.
package am_prototype_trainer_pkg;

   localparam int unsigned HV_DIMENSION_DEF = 2000;
   localparam int unsigned AM_CHUNK_DEF     = 250;
   localparam int unsigned LABEL_WIDTH_DEF  = 1;
   localparam int unsigned SAMPLE_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE          = 2'd0,
      ACCUM         = 2'd1,
      THRESHOLD     = 2'd2,
      OUTPUT_STABLE = 2'd3
   } trainState_t;

   // Smallest r with 2**r >= value (0 for value <= 1).
   function automatic int unsigned ceilLog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(value)) r++;
      return r;
   endfunction

endpackage

// File: rtl/am_prototype_trainer_train_bit_counter.sv
// train_bit_counter
//   One per-bit vote counter of the prototype trainer. Counts how many
//   bundled samples had this hypervector bit set.
// Ports:
//   Clk_CI    clock
//   Reset_RI  synchronous active-high reset
//   Clear_SI  zero the counter
//   Load_SI   start a new bundle: counter = Bit_DI
//   Add_SI    bundle another sample: counter += Bit_DI
//   Bit_DI    sample bit
//   Count_DO  current vote count
module train_bit_counter
   import am_prototype_trainer_pkg::*;
#(
   parameter int unsigned WIDTH = SAMPLE_WIDTH_DEF
) (
   input  logic             Clk_CI,
   input  logic             Reset_RI,
   input  logic             Clear_SI,
   input  logic             Load_SI,
   input  logic             Add_SI,
   input  logic             Bit_DI,
   output logic [WIDTH-1:0] Count_DO
);

   // The sample counter caps the bundle at 2**WIDTH-1, so Add never wraps.
   always_ff @(posedge Clk_CI) begin
      if (Reset_RI || Clear_SI) Count_DO <= '0;
      else if (Load_SI)         Count_DO <= WIDTH'(Bit_DI);
      else if (Add_SI)          Count_DO <= Count_DO + WIDTH'(Bit_DI);
   end

endmodule

// File: rtl/am_prototype_trainer.sv
// am_prototype_trainer
//   Bundles a stream of labelled training hypervectors by per-bit majority
//   vote and hands out one class prototype per bundle.
//   Build macro: TRAIN_TIEBREAK_EN -- tied bits take TIEBREAK_HV instead of 0
//   (TIEBREAK_HV only exists when the macro is defined).
// Ports:
//   Clk_CI, Reset_RI       clock, synchronous active-high reset
//   ValidIn_SI/ReadyOut_SO input sample handshake
//   HypervectorIn_DI       training sample
//   LabelIn_DI             sample class label
//   LastIn_SI              final sample of the bundle
//   ValidOut_SO/ReadyIn_SI prototype handshake
//   PrototypeOut_DO        bundled prototype
//   LabelOut_DO            label of the first sample of the bundle
//   CountOut_DO            number of samples bundled
//   LabelMismatch_SO       some later sample carried a different label
// HV_DIMENSION must be a multiple of AM_CHUNK.
module am_prototype_trainer
   import am_prototype_trainer_pkg::*;
#(
   parameter int unsigned HV_DIMENSION = HV_DIMENSION_DEF,
   parameter int unsigned AM_CHUNK     = AM_CHUNK_DEF,
   parameter int unsigned LABEL_WIDTH  = LABEL_WIDTH_DEF,
   parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEF
`ifdef TRAIN_TIEBREAK_EN
  ,parameter logic [0:HV_DIMENSION-1] TIEBREAK_HV = '0
`endif
) (
   input  logic                    Clk_CI,
   input  logic                    Reset_RI,
   input  logic                    ValidIn_SI,
   output logic                    ReadyOut_SO,
   input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
   input  logic [LABEL_WIDTH-1:0]  LabelIn_DI,
   input  logic                    LastIn_SI,
   output logic                    ValidOut_SO,
   input  logic                    ReadyIn_SI,
   output logic [0:HV_DIMENSION-1] PrototypeOut_DO,
   output logic [LABEL_WIDTH-1:0]  LabelOut_DO,
   output logic [SAMPLE_WIDTH-1:0] CountOut_DO,
   output logic                    LabelMismatch_SO
);

   localparam int unsigned LOOPS   = HV_DIMENSION / AM_CHUNK;
   localparam int unsigned CHUNK_W = (LOOPS > 1) ? ceilLog2(LOOPS) : 1;
   localparam int unsigned IDX_W   = (HV_DIMENSION > 1) ? ceilLog2(HV_DIMENSION) : 1;
   localparam logic [SAMPLE_WIDTH-1:0] MAX_CNT    = '1;
   localparam logic [CHUNK_W-1:0]      LAST_CHUNK = CHUNK_W'(LOOPS - 1);

   trainState_t                 state_SP;
   logic [SAMPLE_WIDTH-1:0]     sampleCnt_DP;
   logic [SAMPLE_WIDTH-1:0]     sampleCntInc_D;
   logic [CHUNK_W-1:0]          chunkCnt_DP;
   logic [LABEL_WIDTH-1:0]      label_DP;
   logic                        mismatch_SP;

   logic                        accept_S;
   logic                        loadBits_S;
   logic                        addBits_S;
   logic                        clearBits_S;
   logic                        lastChunk_S;

   logic [HV_DIMENSION-1:0][SAMPLE_WIDTH-1:0] bitCnt_D;
   logic [AM_CHUNK-1:0][IDX_W-1:0]            chunkIdx_D;
   logic [AM_CHUNK-1:0]                       chunkBits_D;
   logic [IDX_W-1:0]                          baseIdx_D;

   // Handshake flags depend on the state register only.
   assign ReadyOut_SO = (state_SP == IDLE) || (state_SP == ACCUM);
   assign ValidOut_SO = (state_SP == OUTPUT_STABLE);

   assign accept_S       = ValidIn_SI && ReadyOut_SO;
   assign loadBits_S     = accept_S && (state_SP == IDLE);
   assign addBits_S      = accept_S && (state_SP == ACCUM);
   assign lastChunk_S    = (state_SP == THRESHOLD) && (chunkCnt_DP == LAST_CHUNK);
   // Counts are read combinationally in the last chunk, so they may clear on that edge.
   assign clearBits_S    = lastChunk_S;
   assign sampleCntInc_D = sampleCnt_DP + 1'b1;

   for (genvar i = 0; i < HV_DIMENSION; i++) begin : g_bitCnt
      train_bit_counter #(
         .WIDTH(SAMPLE_WIDTH)
      ) u_bitCnt (
         .Clk_CI   (Clk_CI),
         .Reset_RI (Reset_RI),
         .Clear_SI (clearBits_S),
         .Load_SI  (loadBits_S),
         .Add_SI   (addBits_S),
         .Bit_DI   (HypervectorIn_DI[i]),
         .Count_DO (bitCnt_D[i])
      );
   end

   // Only AM_CHUNK comparators: the current chunk's counts are muxed in.
   // Majority test 2*cnt vs N is done at SAMPLE_WIDTH+1 bits.
   assign baseIdx_D = IDX_W'(chunkCnt_DP) * IDX_W'(AM_CHUNK);

   always_comb begin
      chunkIdx_D  = '0;
      chunkBits_D = '0;
      for (int j = 0; j < AM_CHUNK; j++) begin
         chunkIdx_D[j] = baseIdx_D + IDX_W'(j);
         if ({bitCnt_D[chunkIdx_D[j]], 1'b0} > {1'b0, sampleCnt_DP})
            chunkBits_D[j] = 1'b1;
         else if ({bitCnt_D[chunkIdx_D[j]], 1'b0} < {1'b0, sampleCnt_DP})
            chunkBits_D[j] = 1'b0;
         else begin
`ifdef TRAIN_TIEBREAK_EN
            chunkBits_D[j] = TIEBREAK_HV[chunkIdx_D[j]];
`else
            chunkBits_D[j] = 1'b0;
`endif
         end
      end
   end

   always_ff @(posedge Clk_CI) begin
      if (Reset_RI) begin
         state_SP         <= IDLE;
         sampleCnt_DP     <= '0;
         chunkCnt_DP      <= '0;
         label_DP         <= '0;
         mismatch_SP      <= 1'b0;
         PrototypeOut_DO  <= '0;
         LabelOut_DO      <= '0;
         CountOut_DO      <= '0;
         LabelMismatch_SO <= 1'b0;
      end else begin
         unique case (state_SP)
            IDLE: begin
               if (accept_S) begin
                  sampleCnt_DP <= SAMPLE_WIDTH'(1);
                  label_DP     <= LabelIn_DI;
                  mismatch_SP  <= 1'b0;
                  chunkCnt_DP  <= '0;
                  // With a 1-bit sample counter one sample already fills the bundle.
                  if (LastIn_SI || (MAX_CNT == SAMPLE_WIDTH'(1))) state_SP <= THRESHOLD;
                  else                                             state_SP <= ACCUM;
               end
            end
            ACCUM: begin
               if (accept_S) begin
                  sampleCnt_DP <= sampleCntInc_D;
                  if (LabelIn_DI != label_DP) mismatch_SP <= 1'b1;
                  if (LastIn_SI || (sampleCntInc_D == MAX_CNT)) state_SP <= THRESHOLD;
               end
            end
            THRESHOLD: begin
               for (int j = 0; j < AM_CHUNK; j++)
                  PrototypeOut_DO[chunkIdx_D[j]] <= chunkBits_D[j];
               if (lastChunk_S) begin
                  LabelOut_DO      <= label_DP;
                  CountOut_DO      <= sampleCnt_DP;
                  LabelMismatch_SO <= mismatch_SP;
                  chunkCnt_DP      <= '0;
                  state_SP         <= OUTPUT_STABLE;
               end else begin
                  chunkCnt_DP <= chunkCnt_DP + 1'b1;
               end
            end
            OUTPUT_STABLE: begin
               if (ReadyIn_SI) state_SP <= IDLE;
            end
            default: state_SP <= IDLE;
         endcase
      end
   end

endmodule
